alu_arb: RTL

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 27 ++
 rtl/alu_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU and its two-port arbiter: operation codes and the
// arbiter FSM state encoding.
package alu_pkg;

  // Operation codes. Codes 5..7 are undefined and produce a zero result.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLT = 3'd4
  } alu_op_e;

  // IDLE: result register empty. HOLD: result register full, owner recorded.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU shared by both requesters of alu_arb.
// SLT is an unsigned compare with a zero-extended 1-bit result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // Select the result for the requested operation; undefined codes give zero.
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_SLT:  o_y = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of a single shared ALU, with a
// one-entry registered result (latency 1, back-to-back capable).
// Optional macro ALU_ARB_STATS_EN adds per-port accepted-request counters.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high on the same port; ready never depends on anything but current-cycle
// inputs and state, and a held response stays stable until its owner takes it.
module alu_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  alu_op_e [1:0]         req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output arb_state_e            dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1
`endif
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic             r_owner;
  logic             r_last;
  logic [WIDTH-1:0] r_y;

  logic             w_drain;
  logic             w_can_accept;
  logic             w_gnt;
  logic             w_accept;
  alu_op_e          w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;

  // The granted requester's fields drive the single ALU instance.
  assign w_a  = req_a[w_gnt];
  assign w_b  = req_b[w_gnt];
  assign w_op = req_op[w_gnt];

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_op (w_op),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_y  (w_y)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant selection, acceptance, next state and handshake outputs.
  always_comb begin
    w_drain      = 1'b0;
    w_can_accept = 1'b0;
    w_gnt        = 1'b0;
    w_accept     = 1'b0;
    w_state_nxt  = r_state;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;

    w_drain      = (r_state == HOLD) && rsp_ready[r_owner];
    w_can_accept = (r_state == IDLE) || w_drain;

    // Contention goes to the port that did not win the last accepted transfer.
    case (req_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last;
      default: w_gnt = 1'b0;
    endcase

    // rst is folded in so ready stays low for the whole reset pulse.
    w_accept = w_can_accept && (req_valid != 2'b00) && !rst;

    if (w_accept) begin
      req_ready   = w_gnt ? 2'b10 : 2'b01;
      w_state_nxt = HOLD;
    end else if (w_drain) begin
      w_state_nxt = IDLE;
    end

    if (r_state == HOLD) begin
      rsp_valid = r_owner ? 2'b10 : 2'b01;
    end
  end

  // Result, owner and round-robin pointer; all update only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_accept) begin
      r_y     <= w_y;
      r_owner <= w_gnt;
      r_last  <= w_gnt;
    end
  end

  assign rsp_y     = r_y;
  assign dbg_state = r_state;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_cnt0;
  logic [31:0] r_cnt1;

  // Accepted-request counters per port, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_accept) begin
      if (w_gnt) r_cnt1 <= r_cnt1 + 32'd1;
      else       r_cnt0 <= r_cnt0 + 32'd1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule
